// File: rtl/i2s_slave_clk_tracker.sv
// i2s_slave_clk_tracker: recovers sclk/ws timing from an external I2S master and locks on 16/32-bit framing
//   pclk, rst                 : system clock, synchronous active-high reset
//   en                        : enable; low holds SEARCH with counters cleared (synchronisers keep running)
//   sclk_in, ws_in            : asynchronous I2S bit clock and word select
//   sclk_rise, sclk_fall      : one-cycle strobes per synchronised sclk edge
//   ws, ws_edge, frame_start  : ws sampled on sclk_rise, ws change strobe, left-channel start strobe
//   bit_cnt, word_len         : rises in the current half frame, last completed half-frame length
//   sclk_period               : pclk cycles between the last two sclk rises (saturating)
//   frame_32, locked          : locked framing length flag, lock status
//   len_err, sclk_lost        : length mismatch while locked, sclk timeout pulses
//   jitter_err                : only with I2S_SLAVE_JITTER_CHK_EN, period jitter pulse while locked
module i2s_slave_clk_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int PER_W = 8,
  parameter int TIMEOUT = 255,
  parameter int LOCK_HALVES = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclk_in,
  input  logic             ws_in,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             ws,
  output logic             ws_edge,
  output logic             frame_start,
  output logic [5:0]       bit_cnt,
  output logic [5:0]       word_len,
  output logic [PER_W-1:0] sclk_period,
  output logic             frame_32,
  output logic             locked,
  output logic             len_err,
  output logic             sclk_lost
`ifdef I2S_SLAVE_JITTER_CHK_EN
  ,
  output logic             jitter_err
`endif
);
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  localparam logic [PER_W-1:0] TO_M1 = PER_W'(TIMEOUT - 1);
  localparam logic [7:0] LH = 8'(LOCK_HALVES);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, ws_sync;
  logic sclk_prev, sclk_s, ws_s, rise_d, fall_d, ws_chg, timeout, valid;
  logic [PER_W-1:0] per_cnt, new_per;
  logic [5:0] ref_len, ref_n;
  logic [7:0] match, match_n;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ws_s = ws_sync[SYNC_STAGES-1];
  // strobes and counters all update on the same edge that registers the rise
  assign rise_d = sclk_s & ~sclk_prev;
  assign fall_d = ~sclk_s & sclk_prev;
  assign ws_chg = rise_d & (ws_s != ws);
  assign new_per = per_cnt == '1 ? per_cnt : per_cnt + PER_W'(1);
  assign timeout = state != SEARCH && !rise_d && per_cnt == TO_M1;
  assign valid = word_len == 6'd16 || word_len == 6'd32;
  assign locked = state == LOCKED;
  assign frame_32 = locked && ref_len == 6'd32;
  always_ff @(posedge pclk) begin
    if (rst) begin
      sclk_sync <= '0;
      ws_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ws_sync <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sclk_prev <= sclk_s;
    end
  end
`ifdef I2S_SLAVE_JITTER_CHK_EN
  logic [PER_W-1:0] per_diff;
  assign per_diff = new_per > sclk_period ? new_per - sclk_period : sclk_period - new_per;
`endif
  always_ff @(posedge pclk) begin
    if (rst || !en) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ws <= 1'b0;
      ws_edge <= 1'b0;
      frame_start <= 1'b0;
      bit_cnt <= '0;
      word_len <= '0;
      sclk_period <= '0;
      per_cnt <= '0;
      len_err <= 1'b0;
      sclk_lost <= 1'b0;
`ifdef I2S_SLAVE_JITTER_CHK_EN
      jitter_err <= 1'b0;
`endif
    end else begin
      sclk_rise <= rise_d;
      sclk_fall <= fall_d;
      ws_edge <= ws_chg;
      frame_start <= ws_chg & ~ws_s;
      ws <= rise_d ? ws_s : ws;
      per_cnt <= rise_d ? '0 : new_per;
      sclk_period <= rise_d ? new_per : sclk_period;
      len_err <= locked && ws_edge && word_len != ref_len && !timeout;
      sclk_lost <= timeout;
`ifdef I2S_SLAVE_JITTER_CHK_EN
      jitter_err <= locked && rise_d && per_diff > PER_W'(1);
`endif
      if (timeout) begin
        word_len <= '0;
        bit_cnt <= '0;
      end else if (rise_d) begin
        word_len <= ws_chg ? bit_cnt : word_len;
        bit_cnt <= ws_chg ? 6'd1 : bit_cnt + 6'(bit_cnt != 6'd63);
      end
    end
  end
  always_ff @(posedge pclk) begin
    if (rst || !en) begin
      state <= SEARCH;
      ref_len <= '0;
      match <= '0;
    end else begin
      state <= state_n;
      ref_len <= ref_n;
      match <= match_n;
    end
  end
  // word_len already holds the completed length while ws_edge is high
  always_comb begin
    state_n = state;
    ref_n = ref_len;
    match_n = match;
    if (timeout) state_n = SEARCH;
    else if (ws_edge)
      case (state)
        SEARCH: state_n = MEASURE;
        MEASURE: begin
          if (valid) begin
            ref_n = word_len;
            match_n = 8'd1;
            state_n = VERIFY;
          end
        end
        default: begin
          if (word_len == ref_len) begin
            match_n = state == VERIFY ? match + 8'd1 : match;
            state_n = (state == VERIFY && match + 8'd1 == LH) ? LOCKED : state;
          end else if (valid) begin
            ref_n = word_len;
            match_n = 8'd1;
            state_n = VERIFY;
          end else state_n = MEASURE;
        end
      endcase
  end
endmodule

// File: tb/tb_i2s_slave_clk_tracker.sv
// tb_i2s_slave_clk_tracker: directed self-checking bench for i2s_slave_clk_tracker
module tb_i2s_slave_clk_tracker;
  logic pclk = 0, rst = 1, en = 0, sclk_in = 0, ws_in = 0;
  logic sclk_rise, sclk_fall, ws, ws_edge, frame_start, frame_32, locked, len_err, sclk_lost;
  logic [5:0] bit_cnt, word_len;
  logic [7:0] sclk_period;
  logic [28:0] all_out;
`ifdef I2S_SLAVE_JITTER_CHK_EN
  logic jitter_err;
  int n_jit = 0;
  int jit_per[$];
`endif
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_rise_cyc = 0, lock_cyc = 0, unlock_cyc = 0, len_err_cyc = 0, lost_cyc = 0;
  int n_lock_rise = 0, n_len_err = 0, n_lost = 0;
  logic locked_q = 0;
  int edge_cyc[$], edge_rise[$];
  logic [5:0] edge_len[$], rise_bc[$];
  logic edge_fs[$];

  i2s_slave_clk_tracker dut (
    .pclk(pclk), .rst(rst), .en(en), .sclk_in(sclk_in), .ws_in(ws_in),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .ws(ws), .ws_edge(ws_edge),
    .frame_start(frame_start), .bit_cnt(bit_cnt), .word_len(word_len),
    .sclk_period(sclk_period), .frame_32(frame_32), .locked(locked),
    .len_err(len_err), .sclk_lost(sclk_lost)
`ifdef I2S_SLAVE_JITTER_CHK_EN
    , .jitter_err(jitter_err)
`endif
  );

  assign all_out = {sclk_rise, sclk_fall, ws, ws_edge, frame_start, bit_cnt, word_len,
                    sclk_period, frame_32, locked, len_err, sclk_lost};

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    cyc++;
    if (sclk_rise) begin
      rise_bc.push_back(bit_cnt);
      last_rise_cyc = cyc;
    end
    if (ws_edge) begin
      edge_cyc.push_back(cyc);
      edge_len.push_back(word_len);
      edge_fs.push_back(frame_start);
      edge_rise.push_back(rise_bc.size() - 1);
    end
    if (locked && !locked_q) begin
      lock_cyc = cyc;
      n_lock_rise++;
    end
    if (!locked && locked_q) unlock_cyc = cyc;
    locked_q = locked;
    if (len_err) begin
      n_len_err++;
      len_err_cyc = cyc;
    end
    if (sclk_lost) begin
      n_lost++;
      lost_cyc = cyc;
    end
`ifdef I2S_SLAVE_JITTER_CHK_EN
    if (jitter_err) begin
      n_jit++;
      jit_per.push_back(int'(sclk_period));
    end
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bits(input int n, input logic wsv, input int per);
    for (int i = 0; i < n; i++) begin
      sclk_in = 1;
      ws_in = wsv;
      repeat (per - per / 2) @(negedge pclk);
      sclk_in = 0;
      repeat (per / 2) @(negedge pclk);
    end
  endtask

  task automatic do_reset;
    rst = 1;
    en = 1;
    sclk_in = 0;
    ws_in = 0;
    repeat (3) @(negedge pclk);
    rst = 0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic lock16(input int per);
    drive_bits(16, 1, per);
    drive_bits(16, 0, per);
    drive_bits(16, 1, per);
    drive_bits(16, 0, per);
  endtask

  task automatic flush;
    repeat (4) @(negedge pclk);
    #1;
  endtask

  task automatic test_reset;
    int k;
    do_reset;
    lock16(4);
    flush;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL pre_reset_lock: got %0b expected 1", locked); end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      sclk_in = ~sclk_in;
      @(negedge pclk);
    end
    n_checks++;
    if (all_out !== 29'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst = 0;
    sclk_in = 0;
    repeat (4) @(negedge pclk);
    n_checks++;
    if (all_out !== 29'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
    sclk_in = 1;
    k = 0;
    do begin @(negedge pclk); k++; end while (sclk_rise !== 1'b1 && k < 10);
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL rise_latency: got %0d expected 3", k); end
    sclk_in = 0;
    k = 0;
    do begin @(negedge pclk); k++; end while (sclk_fall !== 1'b1 && k < 10);
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL fall_latency: got %0d expected 3", k); end
  endtask

  task automatic test_stereo16;
    int b;
    do_reset;
    b = edge_cyc.size();
    lock16(8);
    drive_bits(16, 1, 8);
    drive_bits(16, 0, 8);
    flush;
    n_checks++;
    if (edge_cyc.size() - b !== 6) begin n_fail++; $display("FAIL s16_edges: got %0d expected 6", edge_cyc.size() - b); end
    for (int i = 1; i < 6; i++) begin
      n_checks++;
      if (edge_len[b + i] !== 6'd16) begin n_fail++; $display("FAIL s16_len[%0d]: got %0d expected 16", i, edge_len[b + i]); end
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (edge_fs[b + i] !== 1'(i % 2)) begin n_fail++; $display("FAIL s16_frame_start[%0d]: got %0b expected %0b", i, edge_fs[b + i], i % 2); end
    end
    n_checks++;
    if (lock_cyc !== edge_cyc[b + 2] + 1) begin n_fail++; $display("FAIL s16_lock_cyc: got %0d expected %0d", lock_cyc, edge_cyc[b + 2] + 1); end
    n_checks++;
    if ({locked, frame_32} !== 2'b10) begin n_fail++; $display("FAIL s16_lock_f32: got %b expected 10", {locked, frame_32}); end
    n_checks++;
    if (sclk_period !== 8'd8) begin n_fail++; $display("FAIL s16_period: got %0d expected 8", sclk_period); end
    n_checks++;
    if (word_len !== 6'd16) begin n_fail++; $display("FAIL s16_word_len: got %0d expected 16", word_len); end
  endtask

  task automatic test_stereo32;
    int b, r;
    do_reset;
    b = edge_cyc.size();
    drive_bits(32, 1, 4);
    drive_bits(32, 0, 4);
    drive_bits(32, 1, 4);
    drive_bits(32, 0, 4);
    flush;
    n_checks++;
    if (edge_cyc.size() - b !== 4) begin n_fail++; $display("FAIL s32_edges: got %0d expected 4", edge_cyc.size() - b); end
    n_checks++;
    if (lock_cyc !== edge_cyc[b + 2] + 1) begin n_fail++; $display("FAIL s32_lock_cyc: got %0d expected %0d", lock_cyc, edge_cyc[b + 2] + 1); end
    n_checks++;
    if ({locked, frame_32} !== 2'b11) begin n_fail++; $display("FAIL s32_lock_f32: got %b expected 11", {locked, frame_32}); end
    n_checks++;
    if (word_len !== 6'd32) begin n_fail++; $display("FAIL s32_word_len: got %0d expected 32", word_len); end
    n_checks++;
    if (sclk_period !== 8'd4) begin n_fail++; $display("FAIL s32_period: got %0d expected 4", sclk_period); end
    r = edge_rise[b + 3];
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if (rise_bc[r + j] !== 6'(j + 1)) begin n_fail++; $display("FAIL s32_bit_cnt[%0d]: got %0d expected %0d", j, rise_bc[r + j], j + 1); end
    end
  endtask

  task automatic test_len_change;
    int b, le0, lr0;
    do_reset;
    b = edge_cyc.size();
    le0 = n_len_err;
    lr0 = n_lock_rise;
    lock16(8);
    drive_bits(24, 1, 8);
    drive_bits(24, 0, 8);
    drive_bits(24, 1, 8);
    flush;
    n_checks++;
    if (edge_len[b + 5] !== 6'd24) begin n_fail++; $display("FAIL lc_len24: got %0d expected 24", edge_len[b + 5]); end
    n_checks++;
    if (n_len_err - le0 !== 1) begin n_fail++; $display("FAIL lc_len_err_count: got %0d expected 1", n_len_err - le0); end
    n_checks++;
    if (len_err_cyc !== edge_cyc[b + 5] + 1) begin n_fail++; $display("FAIL lc_len_err_cyc: got %0d expected %0d", len_err_cyc, edge_cyc[b + 5] + 1); end
    n_checks++;
    if (unlock_cyc !== edge_cyc[b + 5] + 1) begin n_fail++; $display("FAIL lc_unlock_cyc: got %0d expected %0d", unlock_cyc, edge_cyc[b + 5] + 1); end
    n_checks++;
    if (locked !== 1'b0 || n_lock_rise - lr0 !== 1) begin n_fail++; $display("FAIL lc_no_relock: got locked=%0b rises=%0d expected 0 and 1", locked, n_lock_rise - lr0); end
    drive_bits(16, 0, 8);
    drive_bits(16, 1, 8);
    drive_bits(16, 0, 8);
    flush;
    n_checks++;
    if (n_lock_rise - lr0 !== 2) begin n_fail++; $display("FAIL lc_relock_count: got %0d expected 2", n_lock_rise - lr0); end
    n_checks++;
    if (lock_cyc !== edge_cyc[b + 9] + 1) begin n_fail++; $display("FAIL lc_relock_cyc: got %0d expected %0d", lock_cyc, edge_cyc[b + 9] + 1); end
    n_checks++;
    if (n_len_err - le0 !== 1) begin n_fail++; $display("FAIL lc_len_err_final: got %0d expected 1", n_len_err - le0); end
  endtask

  task automatic test_timeout;
    int k, lo0;
    do_reset;
    lo0 = n_lost;
    lock16(8);
    flush;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL to_prelock: got %0b expected 1", locked); end
    k = 0;
    do begin @(negedge pclk); k++; end while (sclk_lost !== 1'b1 && k < 400);
    #1;
    n_checks++;
    if (n_lost - lo0 !== 1) begin n_fail++; $display("FAIL to_lost_seen: got %0d expected 1", n_lost - lo0); end
    n_checks++;
    if (lost_cyc - last_rise_cyc !== 255) begin n_fail++; $display("FAIL to_delay: got %0d expected 255", lost_cyc - last_rise_cyc); end
    n_checks++;
    if ({locked, frame_32, bit_cnt, word_len} !== 14'd0) begin n_fail++; $display("FAIL to_cleared: got %h expected 0", {locked, frame_32, bit_cnt, word_len}); end
    @(negedge pclk);
    n_checks++;
    if (sclk_lost !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %0b expected 0", sclk_lost); end
  endtask

  task automatic test_en_drop;
    int le0, lo0;
    do_reset;
    lock16(8);
    drive_bits(5, 1, 8);
    le0 = n_len_err;
    lo0 = n_lost;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL en_prelock: got %0b expected 1", locked); end
    en = 0;
    @(negedge pclk);
    n_checks++;
    if (all_out !== 29'd0) begin n_fail++; $display("FAIL en_cleared: got %h expected 0", all_out); end
    drive_bits(11, 1, 8);
    drive_bits(16, 0, 8);
    drive_bits(16, 1, 8);
    #1;
    n_checks++;
    if (n_len_err - le0 !== 0 || n_lost - lo0 !== 0) begin n_fail++; $display("FAIL en_no_pulses: got len_err=%0d lost=%0d expected 0", n_len_err - le0, n_lost - lo0); end
    n_checks++;
    if (all_out !== 29'd0) begin n_fail++; $display("FAIL en_held: got %h expected 0", all_out); end
    en = 1;
    lock16(8);
    flush;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL en_relock: got %0b expected 1", locked); end
  endtask

  task automatic test_saturate;
    int b;
    do_reset;
    b = edge_cyc.size();
    drive_bits(70, 0, 4);
    flush;
    n_checks++;
    if (bit_cnt !== 6'd63) begin n_fail++; $display("FAIL sat_bit_cnt: got %0d expected 63", bit_cnt); end
    n_checks++;
    if (edge_cyc.size() - b !== 0 || word_len !== 6'd0) begin n_fail++; $display("FAIL sat_no_edge: got edges=%0d word_len=%0d expected 0 0", edge_cyc.size() - b, word_len); end
  endtask

`ifdef I2S_SLAVE_JITTER_CHK_EN
  task automatic test_jitter;
    int j0;
    do_reset;
    lock16(8);
    j0 = n_jit;
    drive_bits(4, 1, 8);
    drive_bits(1, 1, 10);
    drive_bits(11, 1, 8);
    flush;
    n_checks++;
    if (n_jit - j0 < 1) begin n_fail++; $display("FAIL jit_pulse: got %0d pulses expected at least 1", n_jit - j0); end
    n_checks++;
    if (jit_per[j0] !== 10) begin n_fail++; $display("FAIL jit_first_period: got %0d expected 10", jit_per[j0]); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL jit_lock_kept: got %0b expected 1", locked); end
    j0 = n_jit;
    drive_bits(4, 0, 8);
    drive_bits(1, 0, 9);
    drive_bits(11, 0, 8);
    flush;
    n_checks++;
    if (n_jit - j0 !== 0) begin n_fail++; $display("FAIL jit_period9: got %0d pulses expected 0", n_jit - j0); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL jit_lock_kept9: got %0b expected 1", locked); end
  endtask
`endif

  initial begin
    test_reset;
    test_stereo16;
    test_stereo32;
    test_len_change;
    test_timeout;
    test_en_drop;
    test_saturate;
`ifdef I2S_SLAVE_JITTER_CHK_EN
    test_jitter;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
